// File: rtl/sha256_pkg.sv
// sha256_pkg
// Shared definitions for the SHA-256 block engine:
//   - state_t : engine FSM states
//   - work_t  : the eight working variables a..h, a in the top bits
//   - K       : the 64 round constants
//   - IV      : the initial hash value H0..H7
//   - big_sigma0/1, small_sigma0/1, ch, maj : the SHA-256 logical functions
package sha256_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Rotations are written as fixed part-selects so each is pure wiring.
    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round
// One purely combinational SHA-256 compression round.
// Ports:
//   cur : working variables a..h entering round t
//   w   : message schedule word W[t]
//   k   : round constant K[t]
//   nxt : working variables a..h after round t
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] w,
    input  logic [31:0] k,
    output work_t       nxt
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1 = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
    assign t2 = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);

    assign nxt.a = t1 + t2;
    assign nxt.b = cur.a;
    assign nxt.c = cur.b;
    assign nxt.d = cur.c;
    assign nxt.e = cur.d + t1;
    assign nxt.f = cur.e;
    assign nxt.g = cur.f;
    assign nxt.h = cur.g;

endmodule

// File: rtl/sha256_block_engine.sv
// sha256_block_engine
// Multi-block SHA-256 compression engine, rounds_per_cycle_p rounds per clock.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   en_i            : global enable; low freezes every register
//   v_i, ready_o    : block handshake (accept on v_i & ready_o)
//   block_i         : pre-padded 512-bit block, W0 in the top word
//   first_i, last_i : block starts / ends a message
//   v_o, digest_o   : digest valid / digest, H0 in the top word
//   yumi_i          : consumer takes the digest (with v_o & en_i)
module sha256_block_engine
    import sha256_pkg::*;
#(
    parameter int rounds_per_cycle_p = 1
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic         v_i,
    output logic         ready_o,
    input  logic [511:0] block_i,
    input  logic         first_i,
    input  logic         last_i,
    output logic         v_o,
    output logic [255:0] digest_o,
    input  logic         yumi_i
);

    localparam int R = rounds_per_cycle_p;

    if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
        $error("sha256_block_engine: rounds_per_cycle_p must be 1, 2, 4, 8 or 16");
    end

    state_t       state_reg;
    state_t       state_next;
    logic [5:0]   cnt_reg;
    logic [31:0]  w_reg [0:15];
    work_t        work_reg;
    logic [31:0]  h_reg [0:7];
    logic         last_reg;
    logic [255:0] digest_reg;

    logic         accept;
    logic         last_step;
    logic [31:0]  w_ext [0:15+R];
    work_t        chain [0:R];
    logic [31:0]  h_sum [0:7];
    logic [255:0] h_flat;
    logic [255:0] iv_flat;
    logic [255:0] work_flat;
    logic [255:0] digest_next;

    assign accept    = v_i & ready_o;
    // Counter wraps to 0 on the final step because 64 is a multiple of R.
    assign last_step = (cnt_reg == 6'(64 - R));
    assign work_flat = work_reg;

    // Schedule window extended by R words; the new words feed both the
    // shifted window and nothing else (rounds only use w_reg[0..R-1]).
    always_comb begin
        for (int i = 0; i < 16; i++) w_ext[i] = w_reg[i];
        for (int i = 16; i < 16 + R; i++) begin
            w_ext[i] = small_sigma1(w_ext[i-2]) + w_ext[i-7]
                     + small_sigma0(w_ext[i-15]) + w_ext[i-16];
        end
    end

    assign chain[0] = work_reg;

    for (genvar gi = 0; gi < R; gi++) begin : g_round
        logic [5:0] k_idx;
        assign k_idx = cnt_reg + 6'(gi);
        sha256_round u_round (
            .cur (chain[gi]),
            .w   (w_reg[gi]),
            .k   (K[k_idx]),
            .nxt (chain[gi+1])
        );
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_hash
        assign h_sum[gi]                     = h_reg[gi] + work_flat[255-32*gi -: 32];
        assign h_flat[255-32*gi -: 32]       = h_reg[gi];
        assign iv_flat[255-32*gi -: 32]      = IV[gi];
        assign digest_next[255-32*gi -: 32]  = h_sum[gi];
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_reg <= IDLE;
        else         state_reg <= state_next;
    end

    // Next-state logic; en_i low holds the current state
    always_comb begin
        state_next = state_reg;
        if (en_i) begin
            case (state_reg)
                IDLE:    if (v_i) state_next = ROUND;
                ROUND:   if (last_step) state_next = FINAL;
                FINAL:   state_next = last_reg ? DONE : IDLE;
                DONE:    if (yumi_i) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs; ready_o is also masked by reset_i so it reads 0 during reset
    always_comb begin
        ready_o  = (state_reg == IDLE) & en_i & ~reset_i;
        v_o      = (state_reg == DONE);
        digest_o = digest_reg;
    end

    // Datapath
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_reg    <= '0;
            work_reg   <= '0;
            last_reg   <= 1'b0;
            digest_reg <= '0;
            for (int i = 0; i < 16; i++) w_reg[i] <= '0;
            for (int i = 0; i < 8; i++)  h_reg[i] <= IV[i];
        end else if (en_i) begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cnt_reg  <= '0;
                        last_reg <= last_i;
                        work_reg <= first_i ? iv_flat : h_flat;
                        for (int i = 0; i < 16; i++) w_reg[i] <= block_i[511-32*i -: 32];
                        if (first_i) begin
                            for (int i = 0; i < 8; i++) h_reg[i] <= IV[i];
                        end
                    end
                end
                ROUND: begin
                    work_reg <= chain[R];
                    cnt_reg  <= cnt_reg + 6'(R);
                    for (int i = 0; i < 16; i++) w_reg[i] <= w_ext[i+R];
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) h_reg[i] <= h_sum[i];
                    if (last_reg) digest_reg <= digest_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_engine.sv
// tb_sha256_block_engine
// Drives four engine instances (1, 2, 4 and 16 rounds per cycle) from shared
// buses with per-instance v_i; expected digests and latencies are queued when
// a last block is sent and compared when the instance raises v_o.
module tb_sha256_block_engine;

    localparam int NDUT = 4;
    localparam int RS [0:NDUT-1] = '{1, 2, 4, 16};

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        int           dut;
        logic [255:0] digest;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    logic            clk = 1'b0;
    logic            reset_i;
    logic            en_i;
    logic [NDUT-1:0] v_i_vec;
    logic [NDUT-1:0] ready_vec;
    logic [NDUT-1:0] v_o_vec;
    logic [511:0]    block;
    logic            first;
    logic            last;
    logic            yumi;
    logic [255:0]    digest_arr [0:NDUT-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        sha256_block_engine #(.rounds_per_cycle_p(RS[gi])) u_dut (
            .clk_i    (clk),
            .reset_i  (reset_i),
            .en_i     (en_i),
            .v_i      (v_i_vec[gi]),
            .ready_o  (ready_vec[gi]),
            .block_i  (block),
            .first_i  (first),
            .last_i   (last),
            .v_o      (v_o_vec[gi]),
            .digest_o (digest_arr[gi]),
            .yumi_i   (yumi)
        );
    end

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present a block to instance d and hold v_i for one accepting edge.
    task automatic send_block(input int d, input logic [511:0] blk, input logic f,
                              input logic l, input logic [255:0] exp_dig, input int extra);
        int   n = 0;
        exp_t e;
        block = blk;
        first = f;
        last  = l;
        while (!ready_vec[d] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("ready_before_send", 256'(ready_vec[d]), 256'(1'b1));
        v_i_vec[d] = 1'b1;
        @(posedge clk); #1;
        v_i_vec[d] = 1'b0;
        $display("send dut=%0d R=%0d first=%0b last=%0b", d, RS[d], f, l);
        if (l) begin
            e.dut    = d;
            e.digest = exp_dig;
            e.lat    = 64 / RS[d] + 2 + extra;
            sb_q.push_back(e);
        end
    endtask

    // Wait (bounded) for v_o on instance d; n counts edges with the accept edge as 1.
    task automatic wait_digest(input int d, input int start);
        int   n = start;
        exp_t e;
        while (!v_o_vec[d] && n < 300) begin
            @(posedge clk); #1; n++;
        end
        check("sb_nonempty", 256'(sb_q.size() != 0), 256'(1'b1));
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("v_o_seen", 256'(v_o_vec[d]), 256'(1'b1));
            check("latency", 256'(n), 256'(e.lat));
            check("digest", digest_arr[e.dut], e.digest);
            $display("digest dut=%0d latency=%0d value=%h", d, n, digest_arr[d]);
        end
    endtask

    task automatic consume(input int d);
        yumi = 1'b1;
        @(posedge clk); #1;
        yumi = 1'b0;
        check("v_o_after_yumi", 256'(v_o_vec[d]), 256'(1'b0));
        $display("consume dut=%0d", d);
    endtask

    initial begin
        int n;
        reset_i = 1'b1;
        en_i    = 1'b1;
        v_i_vec = '0;
        block   = '0;
        first   = 1'b0;
        last    = 1'b0;
        yumi    = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 256'(ready_vec[0]), 256'(1'b0));
        check("reset_v_o", 256'(v_o_vec[0]), 256'(1'b0));
        check("reset_digest", digest_arr[0], 256'h0);
        reset_i = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 256'(ready_vec[0]), 256'(1'b1));

        // "abc", one round per cycle
        send_block(0, BLK_ABC, 1'b1, 1'b1, DIG_ABC, 0);
        wait_digest(0, 1);
        consume(0);

        // Empty message, sixteen rounds per cycle
        send_block(3, BLK_EMPTY, 1'b1, 1'b1, DIG_EMPTY, 0);
        wait_digest(3, 1);
        consume(3);

        // Two-block message, four rounds per cycle
        send_block(2, BLK_TWO1, 1'b1, 1'b0, 256'h0, 0);
        n = 1;
        while (!ready_vec[2] && n < 100) begin
            check("no_v_o_block1", 256'(v_o_vec[2]), 256'(1'b0));
            @(posedge clk); #1; n++;
        end
        check("ready_return", 256'(n), 256'(18));
        check("no_v_o_after_block1", 256'(v_o_vec[2]), 256'(1'b0));
        send_block(2, BLK_TWO2, 1'b0, 1'b1, DIG_TWO, 0);
        wait_digest(2, 1);

        // Backpressure with v_i held high in DONE
        block = BLK_ABC;
        first = 1'b1;
        last  = 1'b1;
        v_i_vec[2] = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            check("bp_v_o", 256'(v_o_vec[2]), 256'(1'b1));
            check("bp_ready", 256'(ready_vec[2]), 256'(1'b0));
            check("bp_digest", digest_arr[2], DIG_TWO);
        end
        v_i_vec[2] = 1'b0;
        consume(2);
        check("bp_no_accept", 256'(ready_vec[2]), 256'(1'b1));

        // Enable low for 7 cycles mid-ROUND, two rounds per cycle
        send_block(1, BLK_ABC, 1'b1, 1'b1, DIG_ABC, 7);
        repeat (5) begin
            @(posedge clk); #1;
        end
        en_i = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            check("en_low_v_o", 256'(v_o_vec[1]), 256'(1'b0));
            check("en_low_ready", 256'(ready_vec[0]), 256'(1'b0));
        end
        en_i = 1'b1;
        wait_digest(1, 13);
        consume(1);

        // Reset mid-ROUND discards the pending message; H returns to IV
        send_block(0, BLK_EMPTY, 1'b1, 1'b1, DIG_EMPTY, 0);
        repeat (10) begin
            @(posedge clk); #1;
        end
        #2 reset_i = 1'b1;
        #1;
        check("midreset_v_o", 256'(v_o_vec[0]), 256'(1'b0));
        check("midreset_ready", 256'(ready_vec[0]), 256'(1'b0));
        check("midreset_digest", digest_arr[0], 256'h0);
        sb_q.delete();
        $display("reset pulse mid-round dut=0");
        @(posedge clk); #1;
        reset_i = 1'b0;
        send_block(0, BLK_ABC, 1'b0, 1'b1, DIG_ABC, 0);
        wait_digest(0, 1);
        consume(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/sha256_block_engine.md
Name: sha256_block_engine

Overview:
Parametrised SHA-256 compression engine that hashes multi-block messages, with a selectable number of rounds per clock.
- Accepts one pre-padded 512-bit block per handshake.
- Keeps the chaining state H0..H7 between blocks and presents the 256-bit digest after the block flagged last.
- Sits between the FSB-side padding/packing logic and the digest return path; successor to the single-block fixed-rate core.

Parameters:
rounds_per_cycle_p, 1, compression rounds per clock; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
clk_i  input  1  sole clock
reset_i  input  1  reset; asynchronous, active-high
en_i  input  1  global enable from FSB; low freezes all state
v_i  input  1  block_i/first_i/last_i valid
ready_o  output  1  engine can accept a block this cycle
block_i  input  512  padded block; block_i[511:480]=W0 ... block_i[31:0]=W15, big-endian words
first_i  input  1  block starts a new message: chain from IV
last_i  input  1  block ends the message: produce a digest
v_o  output  1  digest_o valid
digest_o  output  256  digest; [255:224]=H0 ... [31:0]=H7
yumi_i  input  1  consumer takes the digest this cycle

Behaviour:
Reset values (async, reset_i=1):
- state=IDLE, ready_o=0 during reset, v_o=0, digest_o=0.
- H=IV, round counter=0.
- ready_o goes to 1 on the first cycle after reset deasserts while en_i=1.

Handshake:
- Accept occurs when v_i & ready_o at a rising edge.
- ready_o=1 only in IDLE with en_i=1.
- A digest is consumed when v_o & yumi_i & en_i.
- yumi_i while v_o=0 is ignored.
- v_i while ready_o=0 is ignored; the block is not queued.

State machine:
- IDLE:
  - On accept, latch the 16-word window W[0..15] from block_i and last_i.
  - Working regs a..h load IV if first_i=1, otherwise load current H.
  - If first_i=1, H also loads IV. → ROUND.
- ROUND:
  - Performs rounds_per_cycle_p rounds per cycle using a sliding 16-word schedule window.
  - New W[t]=σ1(W[t-2])+W[t-7]+σ0(W[t-15])+W[t-16], mod 2^32.
  - Counter advances by rounds_per_cycle_p; after round 63 completes → FINAL.
  - Occupancy is 64/rounds_per_cycle_p cycles.
- FINAL (1 cycle):
  - Hi <= Hi + working_i, mod 2^32.
  - If the latched last=1, digest_o <= new H, → DONE; else → IDLE.
- DONE:
  - v_o=1; digest_o held stable.
  - On consume → IDLE; v_o is 0 in the following cycle.

Latency:
- Accept edge to v_o=1 is 64/rounds_per_cycle_p + 2 cycles (R=1: 66; R=16: 6).
- A non-last block returns ready_o=1 after the same count.

Arithmetic:
- All additions are 32-bit and wrap; no carries are retained.
- K constants and IV are the FIPS 180-4 values.

Boundary conditions:
- en_i=0: every register holds, ready_o=0, yumi_i is ignored, v_o/digest_o keep their current values; resume is exact.
- first_i=0 with no prior block since reset: chains from IV, because H was reset to IV.
- first_i=1 while H holds a previous message: H is overwritten and no error is raised.
- Same-cycle consume in DONE and v_i=1: v_i is not accepted (ready_o=0 in DONE).
- reset_i asserted mid-ROUND or mid-DONE: immediate return to reset values; any pending digest is lost.
- last_i=1 and first_i=1 together: single-block message.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant array and IV[0:7] constant.
  - Functions Σ0, Σ1, σ0, σ1, ch, maj.
  - State enum {IDLE, ROUND, FINAL, DONE}.
- Sub-module sha256_round: one combinational round. Inputs are a..h, W[t] and K[t]; outputs are the next a..h. It is instantiated rounds_per_cycle_p times in a chain.
- Schedule window and FSM stay in sha256_block_engine.

Test Plan:
- "abc" single padded block, first=last=1, R=1 → v_o after 66 cycles, digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (block 0x8000…0000), R=16 → v_o at cycle 6, digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", R=4 → no v_o after block 1; ready_o back after 18 cycles; final digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold yumi_i=0 for 10 cycles after v_o, driving v_i=1 throughout → digest stable, ready_o=0, no block accepted; one-cycle yumi → v_o=0 next cycle.
- en_i=0 for 7 cycles mid-ROUND ("abc", R=2) → latency extends by exactly 7; digest unchanged.
- reset_i pulsed mid-ROUND, then "abc" with first_i=0 → outputs cleared immediately; digest equals the "abc" value (IV chained).
